me_unit: RTL and testbench

- Memory-access stage (ME) of the LoongArch 5-stage pipeline.
- Sits between EX and WB and is the receiving end of the EX→ME bus.
- Latches each EX instruction, then collects the synchronous data-SRAM read data that returns in the instruction's first ME cycle and holds it across WB stalls.
- Aligns and extends load data per the EX-supplied size/sign/offset flags, then forwards the final result to WB and to the ID bypass network.

---
 rtl/me_unit_if.sv | 23 ++
 rtl/me_unit.sv | 85 ++++++++
 tb/tb_me_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/me_unit_if.sv
// EX->ME->WB handshake and data bundle seen by the memory-access stage.
// master drives the stage inputs (EX, SRAM, WB side); slave is the ME stage.
interface me_unit_if;
  logic        EX_to_ME_Valid;
  logic [75:0] EX_to_ME_Bus;
  logic        ME_Allow_in;
  logic [31:0] data_sram_rdata;
  logic        ME_to_WB_Valid;
  logic        WB_Allow_in;
  logic [69:0] ME_to_WB_Bus;
  logic [4:0]  ME_dest;
  logic [31:0] ME_Forward_Res;

  modport master (
    output EX_to_ME_Valid, EX_to_ME_Bus, data_sram_rdata, WB_Allow_in,
    input  ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus, ME_dest, ME_Forward_Res
  );

  modport slave (
    input  EX_to_ME_Valid, EX_to_ME_Bus, data_sram_rdata, WB_Allow_in,
    output ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus, ME_dest, ME_Forward_Res
  );
endinterface

// File: rtl/me_unit.sv
// LoongArch memory-access stage: latches the EX instruction, captures the SRAM word
// returned in its first ME cycle, aligns/extends loads and forwards the result.
module me_unit (
  input  logic      clk,
  input  logic      reset,
  me_unit_if.slave  me_if
);

  // Extract and extend a byte or halfword from the read word; byte wins over half.
  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [4:0] flag);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (flag[1:0])
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = flag[1] ? word[31:16] : word[15:0];
    if (flag[3])
      r = flag[4] ? 32'(b) : {24'b0, b};
    else if (flag[2])
      r = flag[4] ? 32'(h) : {16'b0, h};
    else
      r = word;
    return r;
  endfunction

  logic        r_vld_p0;
  logic        r_first_p0;
  logic [4:0]  r_flag_p0;
  logic [31:0] r_pc_p0;
  logic [31:0] r_alu_p0;
  logic        r_rfm_p0;
  logic        r_gr_we_p0;
  logic [4:0]  r_dest_p0;
  logic [31:0] r_rdata_buf_p0;

  logic        w_allow_in;
  logic        w_accept;
  logic [31:0] w_mem_word;
  logic [31:0] w_final;

  assign w_allow_in = !r_vld_p0 || me_if.WB_Allow_in;
  assign w_accept   = w_allow_in && me_if.EX_to_ME_Valid;

  // EX -> ME boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p0       <= 1'b0;
      r_first_p0     <= 1'b0;
      r_flag_p0      <= '0;
      r_pc_p0        <= '0;
      r_alu_p0       <= '0;
      r_rfm_p0       <= 1'b0;
      r_gr_we_p0     <= 1'b0;
      r_dest_p0      <= '0;
      r_rdata_buf_p0 <= '0;
    end else begin
      if (w_allow_in) r_vld_p0 <= me_if.EX_to_ME_Valid;
      if (w_accept) begin
        r_flag_p0  <= me_if.EX_to_ME_Bus[75:71];
        r_pc_p0    <= me_if.EX_to_ME_Bus[70:39];
        r_alu_p0   <= me_if.EX_to_ME_Bus[38:7];
        r_rfm_p0   <= me_if.EX_to_ME_Bus[6];
        r_gr_we_p0 <= me_if.EX_to_ME_Bus[5];
        r_dest_p0  <= me_if.EX_to_ME_Bus[4:0];
      end
      r_first_p0 <= w_accept;
      if (r_first_p0) r_rdata_buf_p0 <= me_if.data_sram_rdata;
    end
  end

  // SRAM data is live only in the first cycle; later cycles see the younger EX address.
  assign w_mem_word = r_first_p0 ? me_if.data_sram_rdata : r_rdata_buf_p0;
  assign w_final    = r_rfm_p0 ? load_align(w_mem_word, r_flag_p0) : r_alu_p0;

  assign me_if.ME_Allow_in    = w_allow_in;
  assign me_if.ME_to_WB_Valid = r_vld_p0;
  assign me_if.ME_to_WB_Bus   = {r_pc_p0, w_final, r_gr_we_p0, r_dest_p0};
  assign me_if.ME_dest        = r_vld_p0 ? r_dest_p0 : 5'd0;
  assign me_if.ME_Forward_Res = w_final;

endmodule

// File: tb/tb_me_unit.sv
// Bench for me_unit: directed load/stall/pipelining cases plus random traffic
// checked every cycle against a transaction-level model of the ME stage.
module tb_me_unit;
  logic clk = 1'b0;
  logic reset;
  me_unit_if ifc ();

  me_unit dut (
    .clk   (clk),
    .reset (reset),
    .me_if (ifc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model of the instruction currently held in ME and the word it loaded.
  logic        m_valid, m_fresh, m_rfm, m_gwe;
  logic [31:0] m_pc, m_alu, m_word;
  logic [4:0]  m_dest, m_flag;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [4:0] f);
    int unsigned v;
    if (f[3]) begin
      v = (w >> (8 * f[1:0])) & 32'hFF;
      if (f[4] && v >= 128) v = v | 32'hFFFFFF00;
    end else if (f[2]) begin
      v = (w >> (16 * f[1])) & 32'hFFFF;
      if (f[4] && v >= 32768) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic drive(input logic exv, input logic [4:0] flag, input logic [31:0] pc,
                       input logic [31:0] alu, input logic rfm, input logic gwe,
                       input logic [4:0] dest, input logic [31:0] rdata, input logic wb);
    ifc.EX_to_ME_Valid  = exv;
    ifc.EX_to_ME_Bus    = {flag, pc, alu, rfm, gwe, dest};
    ifc.data_sram_rdata = rdata;
    ifc.WB_Allow_in     = wb;
  endtask

  task automatic check_model();
    logic [31:0] word, fin;
    word = m_fresh ? ifc.data_sram_rdata : m_word;
    fin  = m_rfm ? ref_load(word, m_flag) : m_alu;
    chk("valid", 70'(ifc.ME_to_WB_Valid), 70'(m_valid));
    chk("allow", 70'(ifc.ME_Allow_in), 70'(!m_valid || ifc.WB_Allow_in));
    chk("bus", ifc.ME_to_WB_Bus, {m_pc, fin, m_gwe, m_dest});
    chk("dest", 70'(ifc.ME_dest), 70'(m_valid ? m_dest : 5'd0));
    chk("fwd", 70'(ifc.ME_Forward_Res), 70'(fin));
  endtask

  task automatic model_update();
    if (reset) begin
      m_valid = 0; m_fresh = 0; m_rfm = 0; m_gwe = 0;
      m_pc = 0; m_alu = 0; m_word = 0; m_dest = 0; m_flag = 0;
    end else begin
      if (m_fresh) m_word = ifc.data_sram_rdata;
      m_fresh = 0;
      if (!m_valid || ifc.WB_Allow_in) begin
        m_valid = ifc.EX_to_ME_Valid;
        if (ifc.EX_to_ME_Valid) begin
          {m_flag, m_pc, m_alu, m_rfm, m_gwe, m_dest} = ifc.EX_to_ME_Bus;
          m_fresh = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic load_case(input string tag, input logic [4:0] flag,
                           input logic [31:0] rdata, input logic [31:0] exp);
    drive(1, flag, 32'h1C000000, 32'h1C000100 | 32'(flag[1:0]), 1, 1, 5'd7, $urandom, 1);
    step();
    drive(0, 5'd0, 0, 0, 0, 0, 0, rdata, 1);
    #1;
    chk(tag, 70'(ifc.ME_Forward_Res), 70'(exp));
    step();
  endtask

  logic [31:0] b2b_data [4];

  initial begin
    reset = 1;
    drive(0, 5'd0, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 0);
    model_update();
    @(posedge clk);
    #1;
    chk("rst_valid", 70'(ifc.ME_to_WB_Valid), 70'd0);
    chk("rst_allow", 70'(ifc.ME_Allow_in), 70'd1);
    chk("rst_dest", 70'(ifc.ME_dest), 70'd0);
    chk("rst_fwd", 70'(ifc.ME_Forward_Res), 70'd0);
    chk("rst_bus", ifc.ME_to_WB_Bus, 70'd0);
    step();
    reset = 0;

    // ld.w with one-cycle latency
    drive(1, 5'b00000, 32'h1C000040, 32'h1C000100, 1, 1, 5'd5, 32'h0, 1);
    step();
    drive(0, 5'd0, 0, 0, 0, 0, 0, 32'h8899AABB, 1);
    #1;
    chk("ldw_valid", 70'(ifc.ME_to_WB_Valid), 70'd1);
    chk("ldw_res", 70'(ifc.ME_Forward_Res), 70'(32'h8899AABB));
    chk("ldw_dest", 70'(ifc.ME_dest), 70'd5);
    chk("ldw_bus", ifc.ME_to_WB_Bus, {32'h1C000040, 32'h8899AABB, 1'b1, 5'd5});
    step();

    load_case("ld_b_11", 5'b11011, 32'h80FF1234, 32'hFFFFFF80);
    load_case("ld_bu_11", 5'b01011, 32'h80FF1234, 32'h00000080);
    load_case("ld_h_10", 5'b10110, 32'h80FF1234, 32'hFFFF80FF);
    load_case("ld_hu_00", 5'b00100, 32'h80FF1234, 32'h00001234);
    load_case("ld_h_11_ign_a0", 5'b10111, 32'h80FF1234, 32'hFFFF80FF);
    load_case("ld_illegal_11", 5'b01101, 32'h80FF1234, 32'h00000012);

    // WB stall on a load while SRAM output changes
    drive(1, 5'b00000, 32'h1C000080, 32'h00001000, 1, 1, 5'd9, 32'h0, 1);
    step();
    drive(1, 5'b00000, 32'h1C000084, 32'h00002000, 0, 1, 5'd3, 32'h11111111, 0);
    #1;
    chk("stall_first", 70'(ifc.ME_Forward_Res), 70'(32'h11111111));
    step();
    for (int i = 0; i < 3; i++) begin
      ifc.data_sram_rdata = 32'hDEADBEEF;
      #1;
      chk("stall_allow", 70'(ifc.ME_Allow_in), 70'd0);
      chk("stall_hold", 70'(ifc.ME_Forward_Res), 70'(32'h11111111));
      step();
    end
    drive(0, 5'd0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1);
    #1;
    chk("stall_release", 70'(ifc.ME_Forward_Res), 70'(32'h11111111));
    step();
    drive(0, 5'd0, 0, 0, 0, 0, 0, 32'h0, 1);
    #1;
    chk("stall_gone", 70'(ifc.ME_to_WB_Valid), 70'd0);
    step();

    // four back-to-back loads, no bubbles
    for (int i = 0; i < 4; i++) b2b_data[i] = $urandom;
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, 5'b00000, 32'h1C000100 + 32'(4 * i), 32'h2000 + 32'(4 * i), 1, 1,
            5'(10 + i), (i > 0) ? b2b_data[(i + 3) % 4] : 32'h0, 1);
      #1;
      if (i > 0) begin
        chk("b2b_valid", 70'(ifc.ME_to_WB_Valid), 70'd1);
        chk("b2b_data", 70'(ifc.ME_Forward_Res), 70'(b2b_data[(i + 3) % 4]));
        chk("b2b_dest", 70'(ifc.ME_dest), 70'(10 + i - 1));
      end
      step();
    end

    // add.w passes alu_result
    drive(1, 5'($urandom), 32'h1C000200, 32'h00000042, 0, 1, 5'd4, $urandom, 1);
    step();
    drive(0, 5'd0, 0, 0, 0, 0, 0, $urandom, 1);
    #1;
    chk("alu_res", 70'(ifc.ME_Forward_Res), 70'h42);
    chk("alu_bus", 70'(ifc.ME_to_WB_Bus[37:6]), 70'h42);
    step();

    // reset during a stalled load
    drive(1, 5'b00000, 32'h1C000300, 32'h3000, 1, 1, 5'd12, 32'h0, 1);
    step();
    drive(0, 5'd0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0);
    step();
    reset = 1;
    step();
    reset = 0;
    #1;
    chk("rst_stall_valid", 70'(ifc.ME_to_WB_Valid), 70'd0);
    chk("rst_stall_dest", 70'(ifc.ME_dest), 70'd0);
    chk("rst_stall_allow", 70'(ifc.ME_Allow_in), 70'd1);
    drive(1, 5'b00000, 32'h1C000304, 32'h3004, 1, 1, 5'd13, 32'h0, 1);
    step();
    drive(0, 5'd0, 0, 0, 0, 0, 0, 32'h0BADC0DE, 1);
    #1;
    chk("rst_fresh", 70'(ifc.ME_Forward_Res), 70'(32'h0BADC0DE));
    step();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom, $urandom,
            1'($urandom), 1'($urandom), 5'($urandom), $urandom,
            1'($urandom_range(0, 3) != 0));
      step();
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
